// File: rtl/data_memory_responder.sv
// Data-memory responder for the MEM stage: single and two-beat word reads/writes
// on a byte-addressed, 16-bit-word array with a registered read port.
module data_memory_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH_WORDS = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] Memory_addressbus,
  input  logic [DATA_W-1:0] Memory_incoming_data_bus,
  input  logic [DATA_W-1:0] Memory_incoming_data_hi,
  input  logic              Memory_writemode,
  input  logic              doubleRead,
  input  logic              doubleWrite,
  output logic [DATA_W-1:0] Memory_databus,
  output logic              rd_valid,
  output logic              rd_beat,
  output logic              mem_busy,
  output logic              addr_err
);

  localparam int unsigned IDX_W = ADDR_W - 1;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Second-beat context captured when a double transfer is accepted
  logic [IDX_W-1:0]  sec_idx;
  logic [DATA_W-1:0] sec_data;
  logic              sec_is_write;

  // Request decode; the low address bit is dropped and only flags addr_err
  logic             accept_c;
  logic [IDX_W-1:0] eff_idx_c;
  logic             is_write_c;
  logic             is_double_c;

  assign accept_c    = (state == IDLE) && req_valid;
  assign eff_idx_c   = Memory_addressbus[ADDR_W-1:1];
  assign is_write_c  = Memory_writemode;
  assign is_double_c = Memory_writemode ? doubleWrite : doubleRead;

  // Next-cycle output values and array port controls
  logic              rd_valid_nxt;
  logic              rd_beat_nxt;
  logic              mem_busy_nxt;
  logic              addr_err_nxt;
  logic              rd_en_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic              we_c;
  logic [IDX_W-1:0]  wr_idx_c;
  logic [DATA_W-1:0] wr_data_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: only an accepted double transfer leaves IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept_c && is_double_c) state_nxt = SECOND;
      SECOND:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / array-control logic per state
  always_comb begin
    rd_valid_nxt = 1'b0;
    rd_beat_nxt  = 1'b0;
    mem_busy_nxt = 1'b0;
    addr_err_nxt = 1'b0;
    rd_en_c      = 1'b0;
    rd_idx_c     = eff_idx_c;
    we_c         = 1'b0;
    wr_idx_c     = eff_idx_c;
    wr_data_c    = Memory_incoming_data_bus;
    unique case (state)
      IDLE: begin
        if (accept_c) begin
          addr_err_nxt = Memory_addressbus[0];
          mem_busy_nxt = is_double_c;
          if (is_write_c) begin
            we_c = 1'b1;
          end else begin
            rd_en_c      = 1'b1;
            rd_valid_nxt = 1'b1;
          end
        end
      end
      SECOND: begin
        if (sec_is_write) begin
          we_c      = 1'b1;
          wr_idx_c  = sec_idx;
          wr_data_c = sec_data;
        end else begin
          rd_en_c      = 1'b1;
          rd_idx_c     = sec_idx;
          rd_valid_nxt = 1'b1;
          rd_beat_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers, registered read port and second-beat capture
  always_ff @(posedge clk) begin
    if (reset) begin
      Memory_databus <= '0;
      rd_valid       <= 1'b0;
      rd_beat        <= 1'b0;
      mem_busy       <= 1'b0;
      addr_err       <= 1'b0;
      sec_idx        <= '0;
      sec_data       <= '0;
      sec_is_write   <= 1'b0;
    end else begin
      rd_valid <= rd_valid_nxt;
      rd_beat  <= rd_beat_nxt;
      mem_busy <= mem_busy_nxt;
      addr_err <= addr_err_nxt;
      if (rd_en_c) begin
        Memory_databus <= mem[rd_idx_c];
      end
      if (accept_c) begin
        sec_idx      <= eff_idx_c + IDX_W'(1);
        sec_data     <= Memory_incoming_data_hi;
        sec_is_write <= is_write_c;
      end
    end
  end

  // Single write port; reset suppresses any write in that cycle
  always_ff @(posedge clk) begin
    if (we_c && !reset) begin
      mem[wr_idx_c] <= wr_data_c;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: directed plan plus randomized traffic.
module tb_data_memory_responder;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic [ADDR_W-1:0] Memory_addressbus;
  logic [DATA_W-1:0] Memory_incoming_data_bus;
  logic [DATA_W-1:0] Memory_incoming_data_hi;
  logic              Memory_writemode;
  logic              doubleRead;
  logic              doubleWrite;
  logic [DATA_W-1:0] Memory_databus;
  logic              rd_valid;
  logic              rd_beat;
  logic              mem_busy;
  logic              addr_err;

  data_memory_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_WORDS(DEPTH)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .req_valid                (req_valid),
    .Memory_addressbus        (Memory_addressbus),
    .Memory_incoming_data_bus (Memory_incoming_data_bus),
    .Memory_incoming_data_hi  (Memory_incoming_data_hi),
    .Memory_writemode         (Memory_writemode),
    .doubleRead               (doubleRead),
    .doubleWrite              (doubleWrite),
    .Memory_databus           (Memory_databus),
    .rd_valid                 (rd_valid),
    .rd_beat                  (rd_beat),
    .mem_busy                 (mem_busy),
    .addr_err                 (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              beat;
    logic              busy;
  } rd_exp_t;

  rd_exp_t      rd_q[$];
  bit           exp_busy[int];
  bit           exp_err[int];
  logic [15:0]  model_mem [DEPTH];

  // Reference model state: is the responder owed a second beat, and of what kind
  bit           m_second;
  bit           m_sec_write;
  int           m_sec_word;
  logic [15:0]  m_sec_data;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares per-cycle flags and pops expected read words on rd_valid
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mem_busy", 32'(mem_busy), 32'(exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0));
      chk("addr_err", 32'(addr_err), 32'(exp_err.exists(cyc) ? exp_err[cyc] : 1'b0));
      if (rd_valid === 1'b1) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk("rd_data", 32'(Memory_databus), 32'(e.data));
          chk("rd_beat", 32'(rd_beat), 32'(e.beat));
        end
      end
    end
  end

  // Drive one request cycle (called at a negedge) and update the model for the next edge
  task automatic drive(input bit v, input int addr, input logic [15:0] d, input logic [15:0] hi,
                       input bit wm, input bit dr, input bit dw);
    int e;
    int w;
    e = cyc + 1;
    req_valid                = v;
    Memory_addressbus        = ADDR_W'(addr);
    Memory_incoming_data_bus = d;
    Memory_incoming_data_hi  = hi;
    Memory_writemode         = wm;
    doubleRead               = dr;
    doubleWrite              = dw;
    w = (addr % 4096) / 2;
    if (m_second) begin
      m_second = 1'b0;
      if (m_sec_write) model_mem[m_sec_word] = m_sec_data;
      else rd_q.push_back('{data: model_mem[m_sec_word], beat: 1'b1, busy: 1'b0});
    end else if (v) begin
      exp_err[e] = addr[0];
      if (wm) begin
        model_mem[w] = d;
        if (dw) begin
          m_second = 1'b1; m_sec_write = 1'b1;
          m_sec_word = (w + 1) % DEPTH; m_sec_data = hi;
          exp_busy[e] = 1'b1;
        end
      end else begin
        rd_q.push_back('{data: model_mem[w], beat: 1'b0, busy: dr});
        if (dr) begin
          m_second = 1'b1; m_sec_write = 1'b0;
          m_sec_word = (w + 1) % DEPTH;
          exp_busy[e] = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [15:0] d);  drive(1, a, d, 16'h0, 1, 0, 0); endtask
  task automatic rd(input int a);                        drive(1, a, 16'h0, 16'h0, 0, 0, 0); endtask
  task automatic dwr(input int a, input logic [15:0] d, input logic [15:0] hi); drive(1, a, d, hi, 1, 0, 1); endtask
  task automatic drd(input int a);                       drive(1, a, 16'h0, 16'h0, 0, 1, 0); endtask
  task automatic idle();                                 drive(0, 0, 16'h0, 16'h0, 0, 0, 0); endtask

  // Reset for one edge with a valid write pending on the bus; reset must win
  task automatic do_reset(input int a, input logic [15:0] d);
    reset             = 1'b1;
    req_valid         = 1'b1;
    Memory_addressbus = ADDR_W'(a);
    Memory_incoming_data_bus = d;
    Memory_writemode  = 1'b1;
    doubleRead        = 1'b0;
    doubleWrite       = 1'b0;
    m_second          = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_databus", 32'(Memory_databus), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_beat", 32'(rd_beat), 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 16'h0;
    m_second = 1'b0; m_sec_write = 1'b0; m_sec_word = 0; m_sec_data = 16'h0;
    reset = 1'b1; req_valid = 1'b0; Memory_addressbus = '0;
    Memory_incoming_data_bus = '0; Memory_incoming_data_hi = '0;
    Memory_writemode = 1'b0; doubleRead = 1'b0; doubleWrite = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    do_reset(16'h0, 16'h0);

    // Single write then single read
    wr(12'h010, 16'hBEEF); rd(12'h010); idle();
    // Double write, then double read of the same pair
    dwr(12'h020, 16'h1111, 16'h2222); idle(); drd(12'h020); idle(); idle();
    // Wrap-around double read; a read offered during busy is ignored
    wr(12'hFFE, 16'hAAAA); wr(12'h000, 16'h5555); drd(12'hFFE); rd(12'h010); idle();
    // Odd address reads the even word and flags addr_err
    rd(12'h011); idle();
    // writemode with doubleRead only is a single write
    wr(12'h032, 16'h3232); drive(1, 12'h030, 16'h3030, 16'h9999, 1, 1, 0);
    idle(); rd(12'h032); rd(12'h030); idle();
    // Reset during the second beat of a double write
    wr(12'h042, 16'h4242); wr(12'h050, 16'h5050);
    dwr(12'h040, 16'h7777, 16'h8888);
    do_reset(12'h050, 16'hDEAD);
    rd(12'h040); rd(12'h042); rd(12'h050); idle();
    // Reset during the second beat of a double read drops beat 1
    drd(12'h020);
    do_reset(12'h060, 16'h0606);
    idle(); idle();

    // Randomized traffic over a seeded window plus the wrap region
    for (int i = 0; i < 36; i++) begin
      int a;
      a = (i < 32) ? (12'h100 + 2 * i) : ((12'hFFC + 2 * (i - 32)) % 4096);
      wr(a, 16'($urandom));
    end
    for (int i = 0; i < 400; i++) begin
      int a;
      bit v;
      a = ($urandom_range(0, 3) == 0) ? ((12'hFFC + $urandom_range(0, 7)) % 4096)
                                      : (12'h100 + $urandom_range(0, 61));
      v = ($urandom_range(0, 9) < 7);
      drive(v, a, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(); idle(); idle();
    chk("pending_reads", 32'(rd_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
